// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: RAM read port on one side, instruction handoff and redirect on the other.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_cs;
  logic                  mem_oe;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] ir;
  logic [ADDR_WIDTH-1:0] ir_pc;
  logic                  ir_valid;
  logic                  ir_ready;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    input  fetch_en, mem_rdata, ir_ready, redirect_valid, redirect_pc,
    output mem_addr, mem_cs, mem_oe, mem_we, ir, ir_pc, ir_valid
  );

  modport slave (
    output fetch_en, mem_rdata, ir_ready, redirect_valid, redirect_pc,
    input  mem_addr, mem_cs, mem_oe, mem_we, ir, ir_pc, ir_valid
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction RAM and hands
// each instruction with its address to execute over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH   = 26,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = ADDR_WIDTH'('h100),
  parameter int unsigned           PC_STEP      = 2,
  parameter int unsigned           READ_LATENCY = 2
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_oe_q, mem_oe_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] ir_pc_q, ir_pc_d;
  logic                  ir_valid_q, ir_valid_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic                  launch;
  logic [ADDR_WIDTH-1:0] launch_addr;

  // Next-state logic; a redirect overrides whatever the state decided.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_cs_d     = mem_cs_q;
    mem_oe_d     = mem_oe_q;
    ir_d         = ir_q;
    ir_pc_d      = ir_pc_q;
    ir_valid_d   = ir_valid_q;
    lat_cnt_d    = lat_cnt_q;
    launch       = 1'b0;
    launch_addr  = pc_q;

    case (state_q)
      IDLE: begin
        if (bus.fetch_en) launch = 1'b1;
      end
      WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          ir_d       = bus.mem_rdata;
          ir_pc_d    = fetch_addr_q;
          ir_valid_d = 1'b1;
          mem_cs_d   = 1'b0;
          mem_oe_d   = 1'b0;
          state_d    = HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      HOLD: begin
        if (bus.ir_ready) begin
          ir_valid_d = 1'b0;
          if (bus.fetch_en) launch = 1'b1;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any completed handshake has already happened above; the redirect then flushes.
    if (bus.redirect_valid) begin
      ir_d        = ir_q;
      ir_pc_d     = ir_pc_q;
      ir_valid_d  = 1'b0;
      pc_d        = bus.redirect_pc;
      launch      = bus.fetch_en;
      launch_addr = bus.redirect_pc;
      if (!bus.fetch_en) begin
        mem_cs_d = 1'b0;
        mem_oe_d = 1'b0;
        state_d  = IDLE;
      end
    end

    if (launch) begin
      mem_addr_d   = launch_addr;
      fetch_addr_d = launch_addr;
      mem_cs_d     = 1'b1;
      mem_oe_d     = 1'b1;
      pc_d         = launch_addr + STEP;
      lat_cnt_d    = LAT_W'(1);
      state_d      = WAIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= '0;
      mem_addr_q   <= '0;
      mem_cs_q     <= 1'b0;
      mem_oe_q     <= 1'b0;
      ir_q         <= '0;
      ir_pc_q      <= '0;
      ir_valid_q   <= 1'b0;
      lat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_cs_q     <= mem_cs_d;
      mem_oe_q     <= mem_oe_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
      ir_valid_q   <= ir_valid_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_cs   = mem_cs_q;
  assign bus.mem_oe   = mem_oe_q;
  assign bus.mem_we   = 1'b0;
  assign bus.ir       = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;

endmodule
